// File: rtl/glyph_pixel_pipe_if.sv
// glyph_pixel_pipe_if: video timing in, char RAM / glyph ROM ports, pixel and delayed timing out
interface glyph_pixel_pipe_if;
   logic        in_de;
   logic        in_hsync;
   logic        in_vsync;
   logic [6:0]  in_x;
   logic [5:0]  in_col;
   logic [10:0] ram_addr;
   logic [7:0]  ram_data;
   logic [9:0]  rom_addr;
   logic [2:0]  rom_data;
   logic        out_pix;
   logic        out_de;
   logic        out_hsync;
   logic        out_vsync;
   modport master (
      output in_de, in_hsync, in_vsync, in_x, in_col, ram_data, rom_data,
      input  ram_addr, rom_addr, out_pix, out_de, out_hsync, out_vsync
   );
   modport slave (
      input  in_de, in_hsync, in_vsync, in_x, in_col, ram_data, rom_data,
      output ram_addr, rom_addr, out_pix, out_de, out_hsync, out_vsync
   );
endinterface

// File: rtl/glyph_pixel_pipe.sv
// glyph_pixel_pipe: text-mode pixel pipeline, 5-cycle latency; define GLYPH_ATTR_INVERT_EN for per-char glyph inversion via ram_data[7]
module glyph_pixel_pipe #(
   parameter int COLS    = 43,
   parameter int ROWS    = 24,
   parameter int GLYPH_H = 5,
   parameter int LATENCY = 5
) (
   input logic               clk,
   input logic               rst,
   glyph_pixel_pipe_if.slave bus
);
   localparam int TRW = (ROWS > 1) ? $clog2(ROWS) : 1;
   if (LATENCY != 5) begin : g_latency_check
      $error("glyph_pixel_pipe is built for a fixed depth of 5");
   end
   logic           r_de_prev;
   logic           r_vs_prev;
   logic [2:0]     r_line;
   logic [TRW-1:0] r_row;
   logic [10:0]    r_base;
   logic           r_beyond;
   logic [2:0]     r_line1;
   logic [2:0]     r_line2;
   logic [2:0]     r_sync [1:4];
   logic           r_ok   [1:4];
   logic [1:0]     r_rem  [1:4];
   logic           w_de_fall;
   logic           w_vs_rise;
   logic [8:0]     w_diff;
   logic [1:0]     w_rem;
   logic           w_bit;
   logic           w_glyph;
   // edge detects and remainder/bit selection; an inconsistent quotient saturates rem to 3
   always_comb begin
      w_de_fall = r_de_prev & ~bus.in_de;
      w_vs_rise = ~r_vs_prev & bus.in_vsync;
      w_diff    = {2'b00, bus.in_x} - 9'(bus.in_col) * 9'd3;
      w_rem     = (w_diff > 9'd2) ? 2'd3 : w_diff[1:0];
      w_bit     = (r_rem[4] == 2'd0) ? bus.rom_data[2] :
                  (r_rem[4] == 2'd1) ? bus.rom_data[1] : bus.rom_data[0];
   end
   // line/row tracking: advance on de falling edge, restart on vsync rising edge (vsync wins)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_de_prev <= 1'b0;
         r_vs_prev <= 1'b0;
         r_line    <= '0;
         r_row     <= '0;
         r_base    <= '0;
         r_beyond  <= 1'b0;
      end else begin
         r_de_prev <= bus.in_de;
         r_vs_prev <= bus.in_vsync;
         if (w_vs_rise) begin
            r_line   <= '0;
            r_row    <= '0;
            r_base   <= '0;
            r_beyond <= 1'b0;
         end else if (w_de_fall && !r_beyond) begin
            if (r_line == 3'(GLYPH_H - 1)) begin
               r_line <= '0;
               if (r_row == TRW'(ROWS - 1)) begin
                  r_beyond <= 1'b1;
               end else begin
                  r_row  <= r_row + 1'b1;
                  r_base <= r_base + 11'(COLS);
               end
            end else begin
               r_line <= r_line + 3'd1;
            end
         end
      end
   end
   // pixel pipeline: line and blanking decision travel with each pixel so counter updates never
   // disturb pixels already in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ram_addr  <= '0;
         bus.rom_addr  <= '0;
         bus.out_pix   <= 1'b0;
         bus.out_de    <= 1'b0;
         bus.out_hsync <= 1'b0;
         bus.out_vsync <= 1'b0;
         r_line1       <= '0;
         r_line2       <= '0;
         for (int i = 1; i <= 4; i++) begin
            r_sync[i] <= '0;
            r_ok[i]   <= 1'b0;
            r_rem[i]  <= '0;
         end
      end else begin
         bus.ram_addr <= r_base + 11'(bus.in_col);
         r_sync[1]    <= {bus.in_de, bus.in_hsync, bus.in_vsync};
         r_ok[1]      <= bus.in_de & ~r_beyond & (w_rem != 2'd3);
         r_rem[1]     <= w_rem;
         r_line1      <= r_line;
         r_line2      <= r_line1;
         for (int i = 2; i <= 4; i++) begin
            r_sync[i] <= r_sync[i-1];
            r_ok[i]   <= r_ok[i-1];
            r_rem[i]  <= r_rem[i-1];
         end
         bus.rom_addr  <= {bus.ram_data[6:0], r_line2};
         bus.out_pix   <= r_ok[4] & w_glyph;
         bus.out_de    <= r_sync[4][2];
         bus.out_hsync <= r_sync[4][1];
         bus.out_vsync <= r_sync[4][0];
      end
   end
`ifdef GLYPH_ATTR_INVERT_EN
   logic r_attr3;
   logic r_attr4;
   // attribute bit follows the pixel from the char fetch to the output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_attr3 <= 1'b0;
         r_attr4 <= 1'b0;
      end else begin
         r_attr3 <= bus.ram_data[7];
         r_attr4 <= r_attr3;
      end
   end
   assign w_glyph = w_bit ^ r_attr4;
`else
   logic w_unused_attr;
   assign w_unused_attr = bus.ram_data[7];
   assign w_glyph       = w_bit;
`endif
endmodule
